ula_flag_wb: RTL and testbench

Result/flag writeback stage that sits on the output side of the ALUs (`ULA_LO` and the arithmetic unit). It accepts one ALU result per handshake and holds it in a one-entry output register until the register file takes it. It maintains the architectural flag register {O,C,S,Z}, updating only the flags each OP class is defined to produce. It evaluates branch conditions against the committed flags.

---
 rtl/ula_flag_wb.sv | 165 ++++++++++++++++
 tb/tb_ula_flag_wb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ula_flag_wb.sv
// ula_flag_wb: writeback stage on the ALU output side.
// Holds one ALU result in an output register until the register file
// takes it, keeps the committed {O,C,S,Z} flag register updated with the
// per-OP flag mask, and evaluates branch conditions on the committed flags.
module ula_flag_wb #(
    parameter int bits = 16,
    parameter int RW   = 3
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [4:0]      OP,
    input  logic [bits-1:0] RESU,
    input  logic            O,
    input  logic            C,
    input  logic            S,
    input  logic            Z,
    input  logic [RW-1:0]   DEST,
    output logic            WB_VALID,
    input  logic            WB_READY,
    output logic [bits-1:0] WB_DATA,
    output logic [RW-1:0]   WB_ADDR,
    output logic [3:0]      FLAGS,
    input  logic            CLR_FLAGS,
    input  logic [3:0]      COND,
    output logic            COND_TRUE
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [bits-1:0]   data_r;
    logic [RW-1:0]     addr_r;
    logic [3:0]        flags_r;
    logic [3:0]        flags_nx_s;
    logic [3:0]        flags_base_s;
    logic [3:0]        mask_s;
    logic              writes_s;
    logic              accept_s;
    logic              drain_s;
    logic              cond_s;

    assign IN_READY = !RST && ((state_r == ST_EMPTY) || WB_READY);
    assign accept_s = IN_VALID && IN_READY;
    assign drain_s  = (state_r == ST_FULL) && WB_READY;

    assign WB_VALID  = (state_r == ST_FULL);
    assign WB_DATA   = data_r;
    assign WB_ADDR   = addr_r;
    assign FLAGS     = flags_r;
    assign COND_TRUE = cond_s;

    // Decode which flags an OP produces and whether it writes back.
    always_comb begin
        mask_s   = 4'b0000;
        writes_s = 1'b0;
        casez (OP)
            5'b00???: begin mask_s = 4'b1111; writes_s = 1'b1; end
            5'b0100?: begin mask_s = 4'b0111; writes_s = 1'b1; end
            5'b01???: begin mask_s = 4'b0000; writes_s = 1'b0; end
            5'b10000: begin mask_s = 4'b0001; writes_s = 1'b1; end
            5'b10011: begin mask_s = 4'b0000; writes_s = 1'b1; end
            5'b11111: begin mask_s = 4'b0000; writes_s = 1'b1; end
            5'b1????: begin mask_s = 4'b0011; writes_s = 1'b1; end
            default:  begin mask_s = 4'b0000; writes_s = 1'b0; end
        endcase
    end

    // Next-state logic for the one-entry output register.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s && writes_s) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (accept_s) begin
                    state_nx_s = writes_s ? ST_FULL : ST_EMPTY;
                end else if (drain_s) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: state_nx_s = ST_EMPTY;
        endcase
    end

    // Next flag value: clear first, then the masked update overrides its bits.
    always_comb begin
        flags_base_s = CLR_FLAGS ? 4'b0000 : flags_r;
        flags_nx_s   = flags_base_s;
        if (accept_s) begin
            flags_nx_s = (flags_base_s & ~mask_s) | ({O, C, S, Z} & mask_s);
        end else begin
            flags_nx_s = flags_base_s;
        end
    end

    // Branch condition evaluation on committed flags only.
    always_comb begin
        cond_s = 1'b0;
        case (COND)
            4'd0:    cond_s = 1'b1;
            4'd1:    cond_s = flags_r[0];
            4'd2:    cond_s = !flags_r[0];
            4'd3:    cond_s = flags_r[1];
            4'd4:    cond_s = !flags_r[1];
            4'd5:    cond_s = flags_r[2];
            4'd6:    cond_s = !flags_r[2];
            4'd7:    cond_s = flags_r[3];
            4'd8:    cond_s = !flags_r[3];
            4'd9:    cond_s = flags_r[1] ^ flags_r[3];
            4'd10:   cond_s = !(flags_r[1] ^ flags_r[3]);
            4'd11:   cond_s = flags_r[0] | (flags_r[1] ^ flags_r[3]);
            4'd12:   cond_s = !flags_r[0] & !(flags_r[1] ^ flags_r[3]);
            4'd13:   cond_s = flags_r[2] & !flags_r[0];
            4'd14:   cond_s = !flags_r[2] | flags_r[0];
            4'd15:   cond_s = 1'b0;
            default: cond_s = 1'b0;
        endcase
    end

    // State register; reset drops any held entry without writeback.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Result/destination register, loaded on every accept.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_r <= {bits{1'b0}};
            addr_r <= {RW{1'b0}};
        end else if (accept_s) begin
            data_r <= RESU;
            addr_r <= DEST;
        end else begin
            data_r <= data_r;
            addr_r <= addr_r;
        end
    end

    // Architectural flag register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_r <= 4'b0000;
        end else begin
            flags_r <= flags_nx_s;
        end
    end

endmodule

// File: tb/tb_ula_flag_wb.sv
// Self-checking bench for ula_flag_wb: directed table, hand-written
// backpressure/reset sequences, then randomized traffic against a model.
module tb_ula_flag_wb;

    logic        CLK = 1'b0;
    logic        RST, IN_VALID, WB_READY, CLR_FLAGS;
    logic        O, C, S, Z;
    logic [4:0]  OP;
    logic [15:0] RESU;
    logic [2:0]  DEST;
    logic [3:0]  COND;
    logic        IN_READY, WB_VALID, COND_TRUE;
    logic [15:0] WB_DATA;
    logic [2:0]  WB_ADDR;
    logic [3:0]  FLAGS;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_valid;
    logic [15:0] m_data;
    logic [2:0]  m_addr;
    logic [3:0]  m_flags;

    ula_flag_wb #(.bits(16), .RW(3)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP(OP), .RESU(RESU), .O(O), .C(C), .S(S), .Z(Z), .DEST(DEST),
        .WB_VALID(WB_VALID), .WB_READY(WB_READY), .WB_DATA(WB_DATA),
        .WB_ADDR(WB_ADDR), .FLAGS(FLAGS), .CLR_FLAGS(CLR_FLAGS),
        .COND(COND), .COND_TRUE(COND_TRUE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, iv;
        logic [4:0]  op;
        logic [15:0] resu;
        logic [3:0]  f;
        logic [2:0]  dest;
        logic        wbr, clr;
        logic [3:0]  cond;
        logic [3:0]  e_flags;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_cond;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // flags each OP produces, by OP number ranges
    function automatic logic [3:0] m_mask(input logic [4:0] op);
        int v = int'(op);
        if (v < 8) return 4'b1111;
        if (v == 8 || v == 9) return 4'b0111;
        if (v >= 10 && v <= 15) return 4'b0000;
        if (v == 16) return 4'b0001;
        if (v == 19 || v == 31) return 4'b0000;
        return 4'b0011;
    endfunction

    function automatic bit m_writes(input logic [4:0] op);
        int v = int'(op);
        return !(v >= 10 && v <= 15);
    endfunction

    function automatic bit m_cond(input logic [3:0] f, input logic [3:0] c);
        bit o = f[3], cy = f[2], s = f[1], z = f[0];
        bit lt = (s != o);
        case (int'(c))
            0: return 1'b1;   1: return z;    2: return !z;
            3: return s;      4: return !s;   5: return cy;
            6: return !cy;    7: return o;    8: return !o;
            9: return lt;     10: return !lt; 11: return z || lt;
            12: return !z && !lt;  13: return cy && !z;
            14: return !cy || z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_ready();
        return !RST && (!m_valid || WB_READY);
    endfunction

    // advance the model by one clock edge using the currently driven inputs
    task automatic model_edge();
        bit acc = IN_VALID && m_ready();
        bit drn = m_valid && WB_READY;
        logic [3:0] mk;
        if (RST) begin
            m_valid = 0; m_data = 16'h0000; m_addr = 3'd0; m_flags = 4'b0000;
        end else begin
            if (CLR_FLAGS) m_flags = 4'b0000;
            if (acc) begin
                mk = m_mask(OP);
                m_flags = (m_flags & ~mk) | ({O, C, S, Z} & mk);
                m_data  = RESU;
                m_addr  = DEST;
                m_valid = m_writes(OP);
            end else if (drn) begin
                m_valid = 0;
            end
        end
    endtask

    // one clock cycle: check combinational outputs, take the edge, check state
    task automatic cycle();
        #1;
        chk("in_ready", IN_READY, m_ready());
        chk("cond_true_pre", COND_TRUE, m_cond(m_flags, COND));
        @(posedge CLK);
        model_edge();
        #1;
        chk("wb_valid", WB_VALID, m_valid);
        chk("flags", FLAGS, m_flags);
        chk("wb_data", WB_DATA, m_data);
        chk("wb_addr", WB_ADDR, m_addr);
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [4:0] op,
                         input logic [15:0] resu, input logic [3:0] f, input logic [2:0] dest,
                         input logic wbr, input logic clr, input logic [3:0] cond);
        RST = rst; IN_VALID = iv; OP = op; RESU = resu; {O, C, S, Z} = f;
        DEST = dest; WB_READY = wbr; CLR_FLAGS = clr; COND = cond;
    endtask

    function automatic vec_t mkv(logic rst, logic iv, logic [4:0] op, logic [15:0] resu,
                                 logic [3:0] f, logic [2:0] dest, logic wbr, logic clr,
                                 logic [3:0] cond, logic [3:0] ef, logic ev,
                                 logic [15:0] ed, logic ec);
        vec_t v;
        v.rst = rst; v.iv = iv; v.op = op; v.resu = resu; v.f = f; v.dest = dest;
        v.wbr = wbr; v.clr = clr; v.cond = cond;
        v.e_flags = ef; v.e_valid = ev; v.e_data = ed; v.e_cond = ec;
        return v;
    endfunction

    initial begin
        //           rst   iv    op        resu      f        dst   wbr   clr   cond   eflags   ev    edata     econd
        vt[0] = mkv(1'b1, 1'b0, 5'b00000, 16'h0000, 4'b0000, 3'd0, 1'b1, 1'b0, 4'd2, 4'b0000, 1'b0, 16'h0000, 1'b1);
        vt[1] = mkv(1'b0, 1'b0, 5'b00000, 16'h0000, 4'b0000, 3'd0, 1'b1, 1'b0, 4'd1, 4'b0000, 1'b0, 16'h0000, 1'b0);
        vt[2] = mkv(1'b0, 1'b1, 5'b00000, 16'h8000, 4'b1110, 3'd1, 1'b1, 1'b0, 4'd0, 4'b1110, 1'b1, 16'h8000, 1'b1);
        vt[3] = mkv(1'b0, 1'b1, 5'b10001, 16'h0000, 4'b0001, 3'd1, 1'b1, 1'b0, 4'd9, 4'b1101, 1'b1, 16'h0000, 1'b1);
        vt[4] = mkv(1'b0, 1'b1, 5'b10000, 16'h0000, 4'b0001, 3'd3, 1'b1, 1'b1, 4'd1, 4'b0001, 1'b1, 16'h0000, 1'b1);
        vt[5] = mkv(1'b0, 1'b1, 5'b11111, 16'h0001, 4'b1110, 3'd3, 1'b1, 1'b0, 4'd2, 4'b0001, 1'b1, 16'h0001, 1'b0);
        vt[6] = mkv(1'b0, 1'b1, 5'b10000, 16'h0000, 4'b0011, 3'd3, 1'b1, 1'b0, 4'd3, 4'b0001, 1'b1, 16'h0000, 1'b0);
        vt[7] = mkv(1'b0, 1'b1, 5'b01100, 16'h0000, 4'b1111, 3'd4, 1'b1, 1'b0, 4'd1, 4'b0001, 1'b0, 16'h0000, 1'b1);
        vt[8] = mkv(1'b0, 1'b1, 5'b01000, 16'h0002, 4'b0100, 3'd6, 1'b1, 1'b1, 4'd5, 4'b0100, 1'b1, 16'h0002, 1'b1);

        // power-up reset: registers are unknown until the first edges
        drive(1'b1, 1'b0, 5'b00000, 16'h0000, 4'b0000, 3'd0, 1'b1, 1'b0, 4'd0);
        repeat (2) @(posedge CLK);
        #1;
        m_valid = 0; m_data = 16'h0000; m_addr = 3'd0; m_flags = 4'b0000;

        // directed table
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].rst, vt[i].iv, vt[i].op, vt[i].resu, vt[i].f, vt[i].dest,
                  vt[i].wbr, vt[i].clr, vt[i].cond);
            cycle();
            chk($sformatf("row%0d_flags", i), FLAGS, vt[i].e_flags);
            chk($sformatf("row%0d_valid", i), WB_VALID, vt[i].e_valid);
            if (vt[i].e_valid || vt[i].rst)
                chk($sformatf("row%0d_data", i), WB_DATA, vt[i].e_data);
            chk($sformatf("row%0d_cond", i), COND_TRUE, vt[i].e_cond);
        end

        // backpressure: accept, then hold WB_READY low for three cycles
        drive(1'b0, 1'b1, 5'b00000, 16'h1234, 4'b0000, 3'd5, 1'b1, 1'b0, 4'd0);
        cycle();
        chk("bp_load_data", WB_DATA, 16'h1234);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 5'b00000, 16'hFFFF, 4'b1111, 3'd7, 1'b0, 1'b0, 4'd1);
            #1;
            chk("bp_in_ready", IN_READY, 1'b0);
            cycle();
            chk("bp_hold_data", WB_DATA, 16'h1234);
            chk("bp_hold_addr", WB_ADDR, 3'd5);
            chk("bp_hold_valid", WB_VALID, 1'b1);
            chk("bp_hold_flags", FLAGS, 4'b0000);
        end
        // release with a new input: drain and accept on the same edge
        drive(1'b0, 1'b1, 5'b00000, 16'h00FF, 4'b1000, 3'd2, 1'b1, 1'b0, 4'd7);
        cycle();
        chk("bb_data", WB_DATA, 16'h00FF);
        chk("bb_addr", WB_ADDR, 3'd2);
        chk("bb_valid", WB_VALID, 1'b1);
        chk("bb_flags", FLAGS, 4'b1000);
        chk("bb_cond", COND_TRUE, 1'b1);

        // reset while full and stalled
        drive(1'b1, 1'b0, 5'b00000, 16'h0000, 4'b0000, 3'd0, 1'b0, 1'b0, 4'd7);
        cycle();
        chk("rst_valid", WB_VALID, 1'b0);
        chk("rst_flags", FLAGS, 4'b0000);
        chk("rst_cond", COND_TRUE, 1'b0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                  5'($urandom_range(31)), 16'($urandom), 4'($urandom_range(15)),
                  3'($urandom_range(7)), ($urandom_range(1) == 1),
                  ($urandom_range(15) == 0), 4'($urandom_range(15)));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
